// File: rtl/datapath_pipe.sv
// ---------------------------------------------------------------------------
// datapath_pipe
//
// Purpose:
//   Two-stage (EX -> WB) RISC-V integer datapath. The EX stage reads the
//   register file, forwards the value retiring in WB and computes the ALU
//   result combinationally. The WB stage holds one instruction. It either
//   retires an ALU/link/immediate result on the following cycle, or it drives
//   a valid/ready data-memory request and, for loads, waits for the response.
//
// Parameters:
//   XLEN   data width of registers, ALU and memory port
//   NREGS  architectural registers (power of 2, 2..32); the register index is
//          the low $clog2(NREGS) bits of each instruction field
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   InValid/InReady  EX handshake; an instruction moves to WB on InValid&&InReady
//   Instr            rs1=[19:15], rs2=[24:20], rd=[11:7]
//   ImmExt, PCPlus4  extended immediate and link value
//   RegWrite, ResultSrc, MemWrite, ALUSrc, ALUControl   control unit inputs
//   ALUResult, Zero  combinational EX result and its zero flag
//   MemReq*/MemWE/MemAddr/MemWData   data-memory request channel
//   MemRspValid/MemRspData           load response channel
//   a0               current contents of x10 (0 when NREGS <= 10)
// ---------------------------------------------------------------------------
module datapath_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     Instr,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] PCPlus4,
    input  logic            RegWrite,
    input  logic [1:0]      ResultSrc,
    input  logic            MemWrite,
    input  logic            ALUSrc,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            MemReqValid,
    input  logic            MemReqReady,
    output logic            MemWE,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWData,
    input  logic            MemRspValid,
    input  logic [XLEN-1:0] MemRspData,
    output logic [XLEN-1:0] a0
);

    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ALU  = 2'd1,
        REQ  = 2'd2,
        RSP  = 2'd3
    } wb_state_t;

    // Architectural register file; x0 is never written, so it stays 0.
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // WB stage state and the instruction it holds.
    wb_state_t       state_q, state_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [RW-1:0]   wb_rd_q, wb_rd_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [1:0]      wb_result_src_q, wb_result_src_d;
    logic            wb_mem_write_q, wb_mem_write_d;
    logic [XLEN-1:0] wb_alu_q, wb_alu_d;
    logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;
    logic [XLEN-1:0] wb_imm_q, wb_imm_d;
    logic [XLEN-1:0] wb_pc4_q, wb_pc4_d;

    // EX stage combinational signals.
    logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] src_a, src_b;
    logic [XLEN-1:0] alu_result;
    logic            accept;
    logic            ex_is_mem;
    wb_state_t       ex_target;

    // Retirement signals.
    logic            retire;
    logic            fwd_en;
    logic [XLEN-1:0] retire_val;

    // Only a few instruction bits carry register indices; the rest are
    // folded here so the whole field counts as consumed.
    logic            unused_instr;
    assign unused_instr = ^Instr;

    assign rs1_idx = Instr[15 +: RW];
    assign rs2_idx = Instr[20 +: RW];
    assign rd_idx  = Instr[7 +: RW];

    // The WB instruction retires in ALU state, on a store handshake, or when
    // the load response arrives. A load handshake itself does not retire.
    assign retire = (state_q == ALU) ||
                    ((state_q == REQ) && wb_mem_write_q && MemReqReady) ||
                    ((state_q == RSP) && MemRspValid);

    // EX may accept whenever WB is empty or is emptying this very cycle.
    assign InReady = (state_q == IDLE) || retire;
    assign accept  = InValid && InReady;

    // Result selection of the retiring instruction.
    always_comb begin
        retire_val = wb_alu_q;
        case (wb_result_src_q)
            2'b00:   retire_val = wb_alu_q;
            2'b01:   retire_val = MemRspData;
            2'b10:   retire_val = wb_pc4_q;
            default: retire_val = wb_imm_q;
        endcase
    end

    // Forwarding applies only to a real register write this cycle; x0
    // writes are discarded and therefore never forwarded.
    assign fwd_en = retire && wb_reg_write_q && (wb_rd_q != '0);

    // Operand read: x0 reads zero, otherwise take the retiring value when it
    // targets the same register, otherwise the register file.
    always_comb begin
        rs1_val = regs_q[rs1_idx];
        rs2_val = regs_q[rs2_idx];
        if (rs1_idx == '0) begin
            rs1_val = '0;
        end else if (fwd_en && (wb_rd_q == rs1_idx)) begin
            rs1_val = retire_val;
        end
        if (rs2_idx == '0) begin
            rs2_val = '0;
        end else if (fwd_en && (wb_rd_q == rs2_idx)) begin
            rs2_val = retire_val;
        end
    end

    assign src_a = rs1_val;
    assign src_b = ALUSrc ? ImmExt : rs2_val;

    // ALU; shifts use only the low log2(XLEN) bits of the second operand.
    always_comb begin
        alu_result = '0;
        case (ALUControl)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110:  alu_result = src_a << src_b[SW-1:0];
            default: alu_result = src_a >> src_b[SW-1:0];
        endcase
    end

    assign ALUResult = alu_result;
    assign Zero      = (alu_result == '0);

    // Anything that loads (ResultSrc=01) or stores goes through the memory
    // port; everything else retires straight from the ALU state.
    assign ex_is_mem = (ResultSrc == 2'b01) || MemWrite;
    assign ex_target = ex_is_mem ? REQ : ALU;

    // WB next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ex_target;
                end
            end
            ALU: begin
                state_d = accept ? ex_target : IDLE;
            end
            REQ: begin
                if (MemReqReady) begin
                    if (wb_mem_write_q) begin
                        state_d = accept ? ex_target : IDLE;
                    end else begin
                        state_d = RSP;
                    end
                end
            end
            default: begin
                if (MemRspValid) begin
                    state_d = accept ? ex_target : IDLE;
                end
            end
        endcase
        mem_req_valid_d = (state_d == REQ);
    end

    // EX->WB pipeline register; loads only when an instruction is accepted,
    // so the request fields stay stable while a request is pending.
    always_comb begin
        wb_rd_d         = wb_rd_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_result_src_d = wb_result_src_q;
        wb_mem_write_d  = wb_mem_write_q;
        wb_alu_d        = wb_alu_q;
        wb_wdata_d      = wb_wdata_q;
        wb_imm_d        = wb_imm_q;
        wb_pc4_d        = wb_pc4_q;
        if (accept) begin
            wb_rd_d         = rd_idx;
            wb_reg_write_d  = RegWrite;
            wb_result_src_d = ResultSrc;
            wb_mem_write_d  = MemWrite;
            wb_alu_d        = alu_result;
            wb_wdata_d      = rs2_val;
            wb_imm_d        = ImmExt;
            wb_pc4_d        = PCPlus4;
        end
    end

    // Register file write at retirement.
    always_comb begin
        regs_d = regs_q;
        if (fwd_en) begin
            regs_d[wb_rd_q] = retire_val;
        end
    end

    // All state. Reset abandons any outstanding request or response: the
    // FSM returns to IDLE and the request valid drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            mem_req_valid_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_result_src_q <= 2'b00;
            wb_mem_write_q  <= 1'b0;
            wb_alu_q        <= '0;
            wb_wdata_q      <= '0;
            wb_imm_q        <= '0;
            wb_pc4_q        <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            mem_req_valid_q <= mem_req_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_result_src_q <= wb_result_src_d;
            wb_mem_write_q  <= wb_mem_write_d;
            wb_alu_q        <= wb_alu_d;
            wb_wdata_q      <= wb_wdata_d;
            wb_imm_q        <= wb_imm_d;
            wb_pc4_q        <= wb_pc4_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign MemReqValid = mem_req_valid_q;
    assign MemWE       = wb_mem_write_q;
    assign MemAddr     = wb_alu_q;
    assign MemWData    = wb_wdata_q;

    generate
        if (NREGS > 10) begin : g_a0
            assign a0 = regs_q[10];
        end else begin : g_no_a0
            assign a0 = '0;
        end
    endgenerate

endmodule

// File: tb/tb_datapath_pipe.sv
// ---------------------------------------------------------------------------
// tb_datapath_pipe
//
// Directed testbench for datapath_pipe (XLEN=32, NREGS=32). Inputs change one
// time unit after each rising edge; combinational outputs are checked one
// more unit later, registered outputs right after the edge.
// ---------------------------------------------------------------------------
module tb_datapath_pipe;

    logic        clk;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instr;
    logic [31:0] ImmExt;
    logic [31:0] PCPlus4;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        MemWrite;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        MemReqValid;
    logic        MemReqReady;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemRspValid;
    logic [31:0] MemRspData;
    logic [31:0] a0;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    datapath_pipe #(.XLEN(32), .NREGS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .InValid     (InValid),
        .InReady     (InReady),
        .Instr       (Instr),
        .ImmExt      (ImmExt),
        .PCPlus4     (PCPlus4),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .MemWrite    (MemWrite),
        .ALUSrc      (ALUSrc),
        .ALUControl  (ALUControl),
        .ALUResult   (ALUResult),
        .Zero        (Zero),
        .MemReqValid (MemReqValid),
        .MemReqReady (MemReqReady),
        .MemWE       (MemWE),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemRspValid (MemRspValid),
        .MemRspData  (MemRspData),
        .a0          (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an instruction word with only the register fields populated.
    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'b0};
    endfunction

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction plus control to EX and let it settle.
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] imm, input logic rw,
                                 input logic [1:0] rsrc, input logic mw,
                                 input logic asrc, input logic [2:0] actl);
        InValid    = v;
        Instr      = instr;
        ImmExt     = imm;
        RegWrite   = rw;
        ResultSrc  = rsrc;
        MemWrite   = mw;
        ALUSrc     = asrc;
        ALUControl = actl;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, OP_ADD);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst         = 1'b1;
        PCPlus4     = 32'h0000_0104;
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        MemRspData  = 32'h0;
        idle();
        tick();
        tick();
        checkOutput("reset_a0", a0, 32'h0);
        checkOutput("reset_inready", {31'b0, InReady}, 32'h1);
        checkOutput("reset_reqvalid", {31'b0, MemReqValid}, 32'h0);
        rst = 1'b0;
        tick();

        // addi x10,x0,5 followed back-to-back by add x10,x10,x10
        applyStimulus(1'b1, mk(10, 0, 0), 32'd5, 1'b1, 2'b00, 1'b0, 1'b1, OP_ADD);
        checkOutput("addi_ready", {31'b0, InReady}, 32'h1);
        checkOutput("addi_alu", ALUResult, 32'd5);
        tick();
        checkOutput("addi_a0_not_yet", a0, 32'd0);
        applyStimulus(1'b1, mk(10, 10, 10), 32'd0, 1'b1, 2'b00, 1'b0, 1'b0, OP_ADD);
        checkOutput("add_ready_no_stall", {31'b0, InReady}, 32'h1);
        checkOutput("add_fwd_alu", ALUResult, 32'd10);
        tick();
        checkOutput("addi_a0", a0, 32'd5);
        idle();
        tick();
        checkOutput("add_a0", a0, 32'd10);

        // lw x10,0x40(x0) with a slow memory; add x11,x10,x0 waits behind it
        applyStimulus(1'b1, mk(10, 0, 0), 32'h40, 1'b1, 2'b01, 1'b0, 1'b1, OP_ADD);
        checkOutput("lw_accept_ready", {31'b0, InReady}, 32'h1);
        tick();
        applyStimulus(1'b1, mk(11, 10, 0), 32'd0, 1'b1, 2'b00, 1'b0, 1'b0, OP_ADD);
        for (int i = 0; i < 3; i++) begin
            checkOutput("lw_req_stall", {31'b0, InReady}, 32'h0);
            checkOutput("lw_req_valid", {31'b0, MemReqValid}, 32'h1);
            checkOutput("lw_req_we", {31'b0, MemWE}, 32'h0);
            checkOutput("lw_req_addr", MemAddr, 32'h40);
            tick();
        end
        MemReqReady = 1'b1;
        MemRspValid = 1'b1;
        MemRspData  = 32'hBAD0_BAD0;
        #1;
        checkOutput("lw_handshake_stall", {31'b0, InReady}, 32'h0);
        checkOutput("lw_handshake_valid", {31'b0, MemReqValid}, 32'h1);
        tick();
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("lw_rsp_stall", {31'b0, InReady}, 32'h0);
            checkOutput("lw_rsp_reqvalid", {31'b0, MemReqValid}, 32'h0);
            checkOutput("lw_rsp_a0_hold", a0, 32'd10);
            tick();
        end
        MemRspValid = 1'b1;
        MemRspData  = 32'hDEAD_BEEF;
        #1;
        checkOutput("lw_retire_ready", {31'b0, InReady}, 32'h1);
        checkOutput("lw_fwd_alu", ALUResult, 32'hDEAD_BEEF);
        tick();
        MemRspValid = 1'b0;
        checkOutput("lw_a0", a0, 32'hDEAD_BEEF);
        idle();
        tick();

        // addi x10,x0,7 then sw x10,0x10(x0) back-to-back
        applyStimulus(1'b1, mk(10, 0, 0), 32'd7, 1'b1, 2'b00, 1'b0, 1'b1, OP_ADD);
        tick();
        applyStimulus(1'b1, mk(0, 0, 10), 32'h10, 1'b0, 2'b00, 1'b1, 1'b1, OP_ADD);
        checkOutput("sw_accept_ready", {31'b0, InReady}, 32'h1);
        checkOutput("sw_addr_alu", ALUResult, 32'h10);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            checkOutput("sw_req_valid", {31'b0, MemReqValid}, 32'h1);
            checkOutput("sw_req_we", {31'b0, MemWE}, 32'h1);
            checkOutput("sw_req_addr", MemAddr, 32'h10);
            checkOutput("sw_req_wdata", MemWData, 32'd7);
            checkOutput("sw_req_stall", {31'b0, InReady}, 32'h0);
            tick();
        end
        MemReqReady = 1'b1;
        #1;
        checkOutput("sw_handshake_ready", {31'b0, InReady}, 32'h1);
        tick();
        MemReqReady = 1'b0;
        #1;
        checkOutput("sw_done_reqvalid", {31'b0, MemReqValid}, 32'h0);
        checkOutput("sw_a0_unchanged", a0, 32'd7);

        // addi x0,x0,9 then add x10,x0,x0: nothing forwarded through x0
        applyStimulus(1'b1, mk(0, 0, 0), 32'd9, 1'b1, 2'b00, 1'b0, 1'b1, OP_ADD);
        tick();
        applyStimulus(1'b1, mk(10, 0, 0), 32'd0, 1'b1, 2'b00, 1'b0, 1'b0, OP_ADD);
        checkOutput("x0_no_fwd_alu", ALUResult, 32'd0);
        tick();
        // addi x12,x0,-1
        applyStimulus(1'b1, mk(12, 0, 0), 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 1'b1, OP_ADD);
        tick();
        checkOutput("x0_a0", a0, 32'd0);
        // slti x10,x12,1 : -1 < 1 signed
        applyStimulus(1'b1, mk(10, 12, 0), 32'd1, 1'b1, 2'b00, 1'b0, 1'b1, OP_SLT);
        checkOutput("slt_alu", ALUResult, 32'd1);
        checkOutput("slt_zero", {31'b0, Zero}, 32'h0);
        tick();
        // slli x10,x10,33 : only the low 5 bits of the amount count
        applyStimulus(1'b1, mk(10, 10, 0), 32'd33, 1'b1, 2'b00, 1'b0, 1'b1, OP_SLL);
        checkOutput("sll_alu", ALUResult, 32'd2);
        tick();
        checkOutput("slt_a0", a0, 32'd1);
        // sub x13,x10,x10
        applyStimulus(1'b1, mk(13, 10, 10), 32'd0, 1'b1, 2'b00, 1'b0, 1'b0, OP_SUB);
        checkOutput("sub_alu", ALUResult, 32'd0);
        checkOutput("sub_zero", {31'b0, Zero}, 32'h1);
        tick();
        checkOutput("sll_a0", a0, 32'd2);
        // link write: x10 = PCPlus4
        applyStimulus(1'b1, mk(10, 0, 0), 32'd0, 1'b1, 2'b10, 1'b0, 1'b1, OP_ADD);
        tick();
        // srli x14,x12,4
        applyStimulus(1'b1, mk(14, 12, 0), 32'd4, 1'b1, 2'b00, 1'b0, 1'b1, OP_SRL);
        checkOutput("srl_alu", ALUResult, 32'h0FFF_FFFF);
        tick();
        checkOutput("link_a0", a0, 32'h0000_0104);
        // immediate write: x10 = ImmExt
        applyStimulus(1'b1, mk(10, 0, 0), 32'hABCD_0000, 1'b1, 2'b11, 1'b0, 1'b1, OP_ADD);
        tick();
        idle();
        tick();
        checkOutput("imm_a0", a0, 32'hABCD_0000);

        // Reset while a load request is pending
        applyStimulus(1'b1, mk(10, 0, 0), 32'h30, 1'b1, 2'b01, 1'b0, 1'b1, OP_ADD);
        tick();
        idle();
        checkOutput("rstreq_valid_before", {31'b0, MemReqValid}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rstreq_valid_drop", {31'b0, MemReqValid}, 32'h0);
        checkOutput("rstreq_a0", a0, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Reset while waiting for a load response; the late response is ignored
        applyStimulus(1'b1, mk(10, 0, 0), 32'h20, 1'b1, 2'b01, 1'b0, 1'b1, OP_ADD);
        MemReqReady = 1'b1;
        tick();
        idle();
        checkOutput("rsp_case_req_valid", {31'b0, MemReqValid}, 32'h1);
        checkOutput("rsp_case_stall", {31'b0, InReady}, 32'h0);
        tick();
        MemReqReady = 1'b0;
        #1;
        checkOutput("rsp_wait_reqvalid", {31'b0, MemReqValid}, 32'h0);
        checkOutput("rsp_wait_stall", {31'b0, InReady}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("rstrsp_ready", {31'b0, InReady}, 32'h1);
        checkOutput("rstrsp_reqvalid", {31'b0, MemReqValid}, 32'h0);
        checkOutput("rstrsp_a0", a0, 32'h0);
        tick();
        rst = 1'b0;
        MemRspValid = 1'b1;
        MemRspData  = 32'h1234_5678;
        #1;
        checkOutput("late_rsp_idle_ready", {31'b0, InReady}, 32'h1);
        tick();
        MemRspValid = 1'b0;
        checkOutput("late_rsp_a0", a0, 32'h0);
        checkOutput("late_rsp_reqvalid", {31'b0, MemReqValid}, 32'h0);
        // x11 held 0xDEADBEEF before the resets; it must now read 0
        applyStimulus(1'b1, mk(13, 11, 11), 32'd0, 1'b1, 2'b00, 1'b0, 1'b0, OP_ADD);
        checkOutput("post_rst_reg_read", ALUResult, 32'h0);
        tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
